// File: rtl/normalize_round_pkg.sv
// Shared float16 definitions for the adder datapath (alignment front end and
// normalize/round back end).
package normalize_round_pkg;

  localparam int          EXP_BIAS     = 15;
  localparam int          EMIN         = -14;
  localparam logic [4:0]  EXP_INF      = 5'h1F;
  localparam logic [15:0] QNAN_DEFAULT = 16'h7E00;

  typedef enum logic [1:0] {
    SP_NONE = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_t;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] frac;
  } fp16_t;

endpackage

// File: rtl/normalize_round_lzc14.sv
// Combinational 14-bit leading-one detector: index of the highest set bit,
// plus an all-zero flag (pos is 0 when the input is zero).
module lzc14
  import normalize_round_pkg::*;
(
  input  logic [13:0] din,
  output logic [3:0]  pos,
  output logic        all_zero
);

  always_comb begin
    pos = '0;
    for (int i = 0; i < 14; i++) begin
      if (din[i]) pos = 4'(i);
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/normalize_round.sv
// float16 adder back end: leading-one normalize, round-to-nearest-even, pack.
// Three registered stages (S1 lead/exponent, S2 shift, S3 round/pack).
module normalize_round
  import normalize_round_pkg::*;
#(
  parameter logic [15:0] QNAN_PATTERN = QNAN_DEFAULT,
  parameter bit          EN_FLAGS     = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        DVI,
  output logic        RDY_O,
  input  logic        SUM_SIGN,
  input  logic [6:0]  SUM_EXP,
  input  logic [13:0] SUM_MAG,
  input  logic [1:0]  SPECIAL,
  output logic [15:0] DO,
  output logic        DVO,
  input  logic        RDY_I,
  output logic        OVF,
  output logic        UNF,
  output logic        INEXACT
);

  typedef struct packed {
    logic       sign;
    special_t   special;
    logic       zero;
    logic [8:0] bexp;
    logic       left;
    logic [3:0] amt;
    logic [13:0] mag;
  } s1_t;

  typedef struct packed {
    logic       sign;
    special_t   special;
    logic       zero;
    logic [8:0] bexp;
    logic [12:0] frame;
  } s2_t;

  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        en1, en2, en3;
  s1_t         s1_q, s1_d;
  s2_t         s2_q, s2_d;
  logic [15:0] do_q, do_d;

  assign en3   = !v3_q | RDY_I;
  assign en2   = !v2_q | en3;
  assign en1   = !v1_q | en2;
  assign RDY_O = en1;
  assign DVO   = v3_q;
  assign DO    = do_q;

  always_comb begin
    v1_d = en1 ? DVI  : v1_q;
    v2_d = en2 ? v1_q : v2_q;
    v3_d = en3 ? v2_q : v3_q;
  end

  // S1: biased exponent and signed left-shift amount (negative = right shift)
  logic [3:0] lead_pos;
  logic       mag_zero;
  logic [8:0] sexp_c, bexp_c, shl_c, rsh_c;
  logic       sub_c;

  lzc14 u_lzc (.din(SUM_MAG), .pos(lead_pos), .all_zero(mag_zero));

  always_comb begin
    sexp_c = {{2{SUM_EXP[6]}}, SUM_EXP};
    bexp_c = sexp_c + {5'b0, lead_pos} + 9'(EXP_BIAS - 13);
    sub_c  = bexp_c[8] | (bexp_c == 9'd0);
    // Subnormal targets exponent EMIN, which reduces to SUM_EXP + 13.
    shl_c  = sub_c ? sexp_c + 9'(12 - 13 - EMIN) : 9'd12 - {5'b0, lead_pos};
    rsh_c  = 9'd0 - shl_c;
    s1_d   = s1_q;
    if (en1 && DVI) begin
      s1_d.sign    = SUM_SIGN;
      s1_d.special = special_t'(SPECIAL);
      s1_d.zero    = mag_zero;
      s1_d.bexp    = bexp_c;
      s1_d.left    = !shl_c[8];
      s1_d.amt     = shl_c[8] ? ((rsh_c > 9'd14) ? 4'd14 : rsh_c[3:0]) : shl_c[3:0];
      s1_d.mag     = SUM_MAG;
    end
  end

  // S2: shift into the 13-bit frame; right shifts fold lost bits into sticky
  logic [12:0] lsh_c, frame_c;
  logic [26:0] rsh_frame_c;

  always_comb begin
    lsh_c       = 13'(s1_q.mag << s1_q.amt);
    rsh_frame_c = 27'({s1_q.mag, 14'b0} >> s1_q.amt);
    frame_c     = s1_q.left ? lsh_c
                            : {rsh_frame_c[26:15], rsh_frame_c[14] | (|rsh_frame_c[13:0])};
    s2_d = s2_q;
    if (en2 && v1_q) begin
      s2_d.sign    = s1_q.sign;
      s2_d.special = s1_q.special;
      s2_d.zero    = s1_q.zero;
      s2_d.bexp    = s1_q.bexp;
      s2_d.frame   = frame_c;
    end
  end

  // S3: round to nearest even and pack
  logic        up_c, sub3_c, ovf_c, unf_c, inx_c;
  logic [11:0] sig_c;
  logic [8:0]  exp_c;
  fp16_t       res_c;

  always_comb begin
    up_c   = s2_q.frame[1] & (s2_q.frame[0] | s2_q.frame[2]);
    sig_c  = {1'b0, s2_q.frame[12:2]} + {11'b0, up_c};
    sub3_c = s2_q.bexp[8] | (s2_q.bexp == 9'd0);
    // A subnormal rounding up to 0x400 lands its hidden bit in the exponent LSB.
    exp_c  = sub3_c ? {8'b0, sig_c[10]} : s2_q.bexp + {8'b0, sig_c[11]};
    inx_c  = |s2_q.frame[1:0];
    unf_c  = inx_c & sub3_c;
    ovf_c  = !sub3_c && (exp_c >= {4'b0, EXP_INF});
    res_c  = '{sign: s2_q.sign, exp: exp_c[4:0], frac: sig_c[9:0]};
    if (ovf_c) begin
      res_c.exp  = EXP_INF;
      res_c.frac = '0;
      inx_c      = 1'b1;
      unf_c      = 1'b0;
    end
    case (s2_q.special)
      SP_NAN: begin
        res_c = fp16_t'(QNAN_PATTERN);
        {ovf_c, unf_c, inx_c} = 3'b000;
      end
      SP_INF: begin
        res_c = '{sign: s2_q.sign, exp: EXP_INF, frac: 10'd0};
        {ovf_c, unf_c, inx_c} = 3'b000;
      end
      SP_ZERO: begin
        res_c = '{sign: s2_q.sign, exp: 5'd0, frac: 10'd0};
        {ovf_c, unf_c, inx_c} = 3'b000;
      end
      default: begin
        if (s2_q.zero) begin
          res_c = '0;
          {ovf_c, unf_c, inx_c} = 3'b000;
        end
      end
    endcase
    do_d = do_q;
    if (en3 && v2_q) do_d = res_c;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      do_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      do_q <= do_d;
    end
  end

  generate
    if (EN_FLAGS) begin : g_flags
      logic [2:0] flags_q, flags_d;
      always_comb flags_d = (en3 && v2_q) ? {ovf_c, unf_c, inx_c} : flags_q;
      always_ff @(posedge CLK) begin
        if (RST) flags_q <= '0;
        else     flags_q <= flags_d;
      end
      assign {OVF, UNF, INEXACT} = flags_q;
    end else begin : g_noflags
      assign {OVF, UNF, INEXACT} = 3'b000;
    end
  endgenerate

endmodule
